// File: rtl/smart_down_counter.sv
// One-shot down counter with load priority, registered terminal-count strobe and busy flag.
// Optional auto-reload (periodic port) enabled by defining SMART_DOWN_COUNTER_AUTO_RELOAD_EN.
module smart_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
  input  logic             periodic,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic             tc_n;
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg, reload_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      state    <= state_n;
      count    <= count_n;
      tc_pulse <= tc_n;
      busy     <= (state_n == RUN);
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_reg <= reload_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    tc_n    = 1'b0;
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_n = reload_reg;
`endif
    if (load) begin
      count_n = data_in;
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_n = data_in;
`endif
      state_n = (data_in != '0) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (count == WIDTH'(1)) begin
        tc_n = 1'b1;
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
        if (periodic) begin
          // reload_reg is nonzero whenever RUN was entered, so count never reads 0 here
          count_n = reload_reg;
        end else begin
          count_n = '0;
          state_n = DONE;
        end
`else
        count_n = '0;
        state_n = DONE;
`endif
      end else if (count != '0) begin
        count_n = count - WIDTH'(1);
      end
    end
  end

  assign count_out = count;
  assign zero      = (count == '0);

endmodule

// File: tb/tb_smart_down_counter.sv
// Randomized and directed checks of smart_down_counter against a behavioural model.
// Covers the auto-reload feature when SMART_DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module tb_smart_down_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             enable;
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
  logic             periodic;
`endif
  logic [WIDTH-1:0] count_out;
  logic             zero;
  logic             tc_pulse;
  logic             busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Behavioural model state
  int  m_count;
  int  m_reload;
  bit  m_running;
  bit  m_tc;

  always #5 clk = ~clk;

  smart_down_counter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .enable    (enable),
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
    .periodic  (periodic),
`endif
    .count_out (count_out),
    .zero      (zero),
    .tc_pulse  (tc_pulse),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_count   = 0;
    m_reload  = 0;
    m_running = 0;
    m_tc      = 0;
  endtask

  function automatic bit per_sel();
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
    return periodic;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    m_tc = 0;
    if (load) begin
      m_count   = int'(data_in);
      m_reload  = int'(data_in);
      m_running = (data_in != 0);
    end else if (m_running && enable) begin
      if (m_count - 1 == 0) begin
        m_tc = 1;
        if (per_sel()) m_count = m_reload;
        else begin
          m_count   = 0;
          m_running = 0;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count_out), 32'(m_count));
    check({tag, ".zero"},  32'(zero),      32'(m_count == 0));
    check({tag, ".tc"},    32'(tc_pulse),  32'(m_tc));
    check({tag, ".busy"},  32'(busy),      32'(m_running));
  endtask

  // One clock: model sees the inputs present at the edge, outputs sampled 1ns later
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic l, input logic [WIDTH-1:0] d, input logic e);
    load    = l;
    data_in = d;
    enable  = e;
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    enable  = 1'b0;
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
    periodic = 1'b0;
`endif
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Load 3, run to terminal
    drive(1'b1, 8'd3, 1'b1);
    cycle("ld3");
    load = 1'b0;
    repeat (6) cycle("run3");

    // Load 5 with a pause at 3
    drive(1'b1, 8'd5, 1'b1);
    cycle("ld5");
    load = 1'b0;
    repeat (2) cycle("run5a");
    enable = 1'b0;
    repeat (4) begin
      cycle("pause");
      check("pause_hold", 32'(count_out), 32'd3);
    end
    enable = 1'b1;
    repeat (5) cycle("run5b");

    // Load on the terminal edge wins
    drive(1'b1, 8'd1, 1'b1);
    cycle("ld1");
    drive(1'b1, 8'd7, 1'b1);
    cycle("reld7");
    check("reld7_cnt", 32'(count_out), 32'd7);
    check("reld7_tc",  32'(tc_pulse),  32'd0);
    load = 1'b0;
    repeat (9) cycle("run7");

    // Load 0 stays idle
    drive(1'b1, 8'd0, 1'b1);
    cycle("ld0");
    load = 1'b0;
    repeat (10) cycle("idle0");

    // Full-scale count
    drive(1'b1, 8'hFF, 1'b1);
    cycle("ldff");
    load = 1'b0;
    repeat (254) cycle("runff");
    check("ff_pre_tc", 32'(count_out), 32'd1);
    cycle("ff_term");
    check("ff_tc", 32'(tc_pulse), 32'd1);

    // Asynchronous reset mid-count
    drive(1'b1, 8'd200, 1'b1);
    cycle("ld200");
    load = 1'b0;
    repeat (50) cycle("run200");
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 reset = 1'b0;
    repeat (5) cycle("post_rst");

`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
    periodic = 1'b1;
    drive(1'b1, 8'd2, 1'b1);
    cycle("per_ld2");
    load = 1'b0;
    repeat (8) begin
      cycle("per_run");
      check("per_busy", 32'(busy), 32'd1);
    end
    periodic = 1'b0;
    repeat (4) cycle("per_stop");
    check("per_final", 32'(count_out), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      load    = ($urandom_range(9) == 0);
      data_in = ($urandom_range(7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(6));
      enable  = ($urandom_range(3) != 0);
`ifdef SMART_DOWN_COUNTER_AUTO_RELOAD_EN
      periodic = ($urandom_range(2) != 0);
`endif
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smart_down_counter.md
SMART_DOWN_COUNTER -- requirements
Module: smart_down_counter

Interface
REQ-001 Parameter: WIDTH, 8, bit width of count value and load data.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: load  input  1  loads data_in as start value and reload value.
REQ-005 Port: data_in  input  WIDTH  start/reload value sampled when load=1.
REQ-006 Port: enable  input  1  permits one decrement per clk while running.
REQ-007 Port: periodic  input  1  selects auto-reload at terminal count; present only with SMART_DOWN_COUNTER_AUTO_RELOAD_EN.
REQ-008 Port: count_out  output  WIDTH  current count register.
REQ-009 Port: zero  output  1  high while count_out == 0.
REQ-010 Port: tc_pulse  output  1  registered one-cycle terminal-count strobe.
REQ-011 Port: busy  output  1  high while state is RUN.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered except zero, which is decoded from count_out.
REQ-013 load=1 in any state SHALL, on the next edge, set count and reload_reg to data_in; the state becomes RUN if data_in != 0 and IDLE if data_in == 0.
REQ-014 load SHALL take priority over enable and over terminal-count handling in the same cycle; tc_pulse SHALL be 0 in the cycle after a load.
REQ-015 In RUN with enable=1 and load=0, count SHALL decrement by exactly 1 per edge. With enable=0, count SHALL hold.
REQ-016 In RUN with enable=1, load=0 and count==1 (the terminal edge), count SHALL become 0, tc_pulse SHALL be 1 for exactly the following cycle, and the state SHALL become DONE (one-shot).
REQ-017 In IDLE and DONE, count SHALL hold and enable SHALL be ignored.
REQ-018 Count SHALL never decrement below 0 or wrap to all-ones.
REQ-019 Only load SHALL exit DONE or IDLE.
REQ-020 tc_pulse SHALL be 0 in every cycle not immediately following a terminal edge.
REQ-021 busy SHALL be 1 exactly when the state is RUN.
REQ-022 data_in == 2^WIDTH-1 SHALL count down fully, taking 2^WIDTH-1 enabled cycles to reach terminal.

Reset
REQ-023 reset=1 SHALL immediately, without a clock, set state=IDLE, count=0, reload_reg=0, tc_pulse=0 and busy=0; zero therefore reads 1.
REQ-024 Reset asserted mid-count SHALL abort the count with no tc_pulse. After release, the block SHALL stay in IDLE until load.

Configuration
REQ-025 With macro SMART_DOWN_COUNTER_AUTO_RELOAD_EN defined, the periodic port SHALL exist. On a terminal edge with periodic=1, count SHALL load reload_reg instead of 0, the state SHALL stay RUN, tc_pulse SHALL still assert for one cycle, and count SHALL never read 0 during periodic operation.
REQ-026 With the macro defined and periodic=0, behaviour SHALL be identical to REQ-016.
REQ-027 With the macro undefined, the periodic port and its logic SHALL be absent, and every terminal edge SHALL follow REQ-016.

Verification
REQ-028 Reset, then load data_in=3 and hold enable=1 -> count_out goes 3,2,1,0; tc_pulse=1 only in the cycle count_out first reads 0; busy falls with it; zero=1 from then on.
REQ-029 Load 5, enable=1 for 2 cycles, enable=0 for 4 cycles, then enable=1 -> count_out reads 3 throughout the pause, then reaches 0 with a single tc_pulse.
REQ-030 Load 1 and, at the terminal edge, assert load with data_in=7 -> count_out=7, busy=1, no tc_pulse.
REQ-031 Load 0 -> state IDLE, busy=0, zero=1, no tc_pulse; enable held for 10 cycles leaves count_out=0.
REQ-032 Load 200, run 50 cycles, then pulse reset asynchronously between edges -> count_out=0 immediately with no tc_pulse; enable afterwards leaves count_out=0.
REQ-033 With SMART_DOWN_COUNTER_AUTO_RELOAD_EN, periodic=1, load 2 and enable held -> sequence 2,1,2,1,2,... with tc_pulse every 2 cycles and busy constant 1; dropping periodic to 0 stops at the next terminal with count_out=0.
